gcn_top: RTL and testbench
==========================

GCN_TOP -- requirements
Module: gcn_top

Interface
REQ-001 Parameter N_NODES, default 100: number of graph nodes.
REQ-002 Parameter F_IN, default 8: input feature length per node.
REQ-003 Parameter F_OUT, default 8: weight-matrix column count.
REQ-004 Parameter DW, default 16: data word width.
REQ-005 clk  input  1  the single clock; all state changes on the rising edge.
REQ-006 rst  input  1  reset, synchronous and active-high.
REQ-007 i_req  input  1  job request; qualifies the header word in IDLE.
REQ-008 i_cmd  input  1  word type: 0 = data word, 1 = edge word.
REQ-009 i_p0..i_p15  input  1 each  input word bits; i_p15 is the MSB.
REQ-010 o_rdy  output  1  high for the whole result-streaming window.
REQ-011 o_result  output  1  active-low strobe: 0 = input word consumed this cycle / output word valid; 1 = not consumed / not valid.
REQ-012 o_p0..o_p15  output  1 each  output word bits; o_p15 is the MSB.

Function
REQ-013 Computation: Z[n][c] = sum over f of X[n][f]*W[f][c]; Y[n][c] = Z[n][c] + sum of Z[s][c] over accepted edges s->n (self-loop implicit).
REQ-014 Only two columns, col1 and col2 (0..7), are computed, stored and output.
REQ-015 Arithmetic: signed 16x16 products, accumulation modulo 2^16 (keep low 16 bits, no saturation).
REQ-016 States: IDLE, LOAD_W, LOAD_X, LOAD_E, FIN, OUT.
REQ-017 IDLE: a word with i_req=1 is the header {col2[15:8], col1[7:0]}, with only the low 3 bits of each byte used; capture it, then go to LOAD_W.
REQ-017a IDLE: words with i_req=0 are ignored.
REQ-017b i_req is ignored in every state other than IDLE.
REQ-018 LOAD_W: 64 data words, W row-major (W[0][0..7], W[1][0..7], ...); keep columns col1 and col2 only; after the 64th word go to LOAD_X.
REQ-019 LOAD_X: 800 data words, X row-major per node; on each node's 8th word write Z[n][col1] and Z[n][col2], and initialise Y[n][col1] and Y[n][col2] to the same values; after node 99 go to LOAD_E.
REQ-020 LOAD_E: edge word {src[15:8], dst[7:0]} adds Z[src][c] to Y[dst][c] for both columns in one cycle.
REQ-020a LOAD_E: an edge with src or dst >= 100 is dropped.
REQ-020b LOAD_E: the terminator 16'hFFFF with i_cmd=1 ends input and moves to FIN.
REQ-021 A word whose i_cmd does not match the current phase (1 in LOAD_W/LOAD_X, 0 in LOAD_E) is ignored and not counted.
REQ-022 o_result is 0 in IDLE, LOAD_W, LOAD_X, LOAD_E and OUT.
REQ-022a o_result is 1 for exactly one cycle in FIN.
REQ-022b The loader accepts one word per cycle; there is no stall.
REQ-023 OUT: o_rdy=1 for exactly 201 consecutive cycles.
REQ-023a OUT word order: word 0 = {col2, col1} (8-bit fields); words 1..100 = Y[0..99][col1]; words 101..200 = Y[0..99][col2].
REQ-024 The output word is registered: it changes on the rising edge and is held for the full cycle.
REQ-024a After word 200: o_rdy=0, o_p=0, state returns to IDLE; the next job is accepted immediately.
REQ-025 Duplicate edges accumulate repeatedly; an edge with src=dst adds Z a second time.

Reset
REQ-026 With rst=1 at a rising edge: state=IDLE; o_rdy=0, o_result=0, o_p=16'h0000; all counters cleared.
REQ-026a Z/Y/W storage need not be cleared by reset.
REQ-027 Reset applied mid-job (any state, including OUT) aborts the job within that cycle; no partial output follows.

Verification
REQ-028 Header 16'h0201, W = identity, X[n][f] = n+f, no edges (terminator only) -> word 0 = 16'h0201, Y[n][1] = n+1, Y[n][2] = n+2.
REQ-029 Same job plus edges 16'h0005 and 16'h0105 -> Y[5][1] = 6+1+2 = 9; all other nodes unchanged.
REQ-030 Product overflow: W[0][col1] = 16'h4000, X[n][0] = 4, all other terms 0 -> Y[n][col1] = 16'h0000 (wraps modulo 2^16).
REQ-031 Edge 16'h6400 (src 100), and a data word sent with i_cmd=1 during LOAD_X -> both ignored; results match the job without them.
REQ-032 Terminator accepted -> o_result=1 for exactly 1 cycle, then o_rdy=1 for 201 cycles with o_result=0, then o_rdy=0.
REQ-032a Four back-to-back jobs -> each produces a correct, complete output stream.
REQ-033 rst pulsed during LOAD_X, then a fresh job -> fresh job correct; o_rdy stays low until that job completes.

Source files
------------

// File: rtl/gcn_top.sv
// gcn_top: two-column graph-convolution layer fed by a 16-bit word stream.
// Loads header, W, X and edges, then streams Y for the two selected columns.
module gcn_top #(
   parameter int N_NODES = 100,
   parameter int F_IN    = 8,
   parameter int F_OUT   = 8,
   parameter int DW      = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic i_req,
   input  logic i_cmd,
   input  logic i_p0,
   input  logic i_p1,
   input  logic i_p2,
   input  logic i_p3,
   input  logic i_p4,
   input  logic i_p5,
   input  logic i_p6,
   input  logic i_p7,
   input  logic i_p8,
   input  logic i_p9,
   input  logic i_p10,
   input  logic i_p11,
   input  logic i_p12,
   input  logic i_p13,
   input  logic i_p14,
   input  logic i_p15,
   output logic o_rdy,
   output logic o_result,
   output logic o_p0,
   output logic o_p1,
   output logic o_p2,
   output logic o_p3,
   output logic o_p4,
   output logic o_p5,
   output logic o_p6,
   output logic o_p7,
   output logic o_p8,
   output logic o_p9,
   output logic o_p10,
   output logic o_p11,
   output logic o_p12,
   output logic o_p13,
   output logic o_p14,
   output logic o_p15
);

   localparam int NW = $clog2(N_NODES);
   localparam int FW = $clog2(F_IN);
   localparam int CW = $clog2(F_OUT);
   localparam int OW = $clog2(2 * N_NODES + 2);

   typedef enum logic [2:0] {
      IDLE,
      LOAD_W,
      LOAD_X,
      LOAD_E,
      FIN,
      OUT
   } state_t;

   state_t state;
   state_t state_nx;

   logic [DW-1:0] din;
   logic [DW-1:0] dout;

   logic [2:0]    col1;
   logic [2:0]    col2;
   logic [FW-1:0] w_row;
   logic [CW-1:0] w_col;
   logic [FW-1:0] x_f;
   logic [NW-1:0] x_n;
   logic [OW-1:0] out_cnt;
   logic [DW-1:0] acc1;
   logic [DW-1:0] acc2;

   logic [DW-1:0] w1 [F_IN];
   logic [DW-1:0] w2 [F_IN];
   logic [DW-1:0] z1 [N_NODES];
   logic [DW-1:0] z2 [N_NODES];
   logic [DW-1:0] y1 [N_NODES];
   logic [DW-1:0] y2 [N_NODES];

   logic          data_ok;
   logic          w_end;
   logic          w_last;
   logic          x_end;
   logic          x_last;
   logic          term;
   logic          hit;
   logic          out_end;
   logic [7:0]    src;
   logic [7:0]    dst;
   logic [NW-1:0] se;
   logic [NW-1:0] de;
   logic [DW-1:0] p1;
   logic [DW-1:0] p2;
   logic [DW-1:0] s1;
   logic [DW-1:0] s2;
   logic [DW-1:0] e1;
   logic [DW-1:0] e2;
   logic          hi;
   logic [NW-1:0] ridx;
   logic [DW-1:0] out_word;

   assign din = {i_p15, i_p14, i_p13, i_p12,
                 i_p11, i_p10, i_p9,  i_p8,
                 i_p7,  i_p6,  i_p5,  i_p4,
                 i_p3,  i_p2,  i_p1,  i_p0};

   assign {o_p15, o_p14, o_p13, o_p12,
           o_p11, o_p10, o_p9,  o_p8,
           o_p7,  o_p6,  o_p5,  o_p4,
           o_p3,  o_p2,  o_p1,  o_p0} = dout;

   assign o_rdy    = (state == OUT);
   assign o_result = (state == FIN);

   assign data_ok = !i_cmd;
   assign w_end   = (w_col == CW'(F_OUT - 1));
   assign w_last  = data_ok && w_end && (w_row == FW'(F_IN - 1));
   assign x_end   = (x_f == FW'(F_IN - 1));
   assign x_last  = data_ok && x_end && (x_n == NW'(N_NODES - 1));
   assign term    = i_cmd && (din == 16'hFFFF);
   assign src     = din[15:8];
   assign dst     = din[7:0];
   assign se      = src[NW-1:0];
   assign de      = dst[NW-1:0];
   assign hit     = i_cmd && !term &&
                    (src < 8'(N_NODES)) && (dst < 8'(N_NODES));
   assign out_end = (out_cnt == OW'(2 * N_NODES + 1));

   // Only the low DW bits of each product are kept: wrap, no saturation.
   assign p1 = $signed(din) * $signed(w1[x_f]);
   assign p2 = $signed(din) * $signed(w2[x_f]);
   assign s1 = acc1 + p1;
   assign s2 = acc2 + p2;
   assign e1 = y1[de] + z1[se];
   assign e2 = y2[de] + z2[se];

   always_comb begin
      hi       = (out_cnt > OW'(N_NODES));
      ridx     = hi ? NW'(out_cnt - OW'(N_NODES + 1))
                    : NW'(out_cnt - OW'(1));
      out_word = hi ? y2[ridx] : y1[ridx];
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (i_req)   state_nx = LOAD_W;
         LOAD_W:  if (w_last)  state_nx = LOAD_X;
         LOAD_X:  if (x_last)  state_nx = LOAD_E;
         LOAD_E:  if (term)    state_nx = FIN;
         FIN:                  state_nx = OUT;
         OUT:     if (out_end) state_nx = IDLE;
         default:              state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         col1    <= '0;
         col2    <= '0;
         w_row   <= '0;
         w_col   <= '0;
         x_f     <= '0;
         x_n     <= '0;
         acc1    <= '0;
         acc2    <= '0;
         out_cnt <= '0;
         dout    <= '0;
      end else begin
         unique case (state)
            IDLE: if (i_req) begin
               col1  <= din[2:0];
               col2  <= din[10:8];
               w_row <= '0;
               w_col <= '0;
               x_f   <= '0;
               x_n   <= '0;
               acc1  <= '0;
               acc2  <= '0;
            end
            LOAD_W: if (data_ok) begin
               w_col <= w_end ? '0 : w_col + 1'b1;
               if (w_end) w_row <= w_row + 1'b1;
            end
            LOAD_X: if (data_ok) begin
               x_f  <= x_end ? '0 : x_f + 1'b1;
               acc1 <= x_end ? '0 : s1;
               acc2 <= x_end ? '0 : s2;
               if (x_end) x_n <= x_n + 1'b1;
            end
            FIN: begin
               dout    <= {5'b0, col2, 5'b0, col1};
               out_cnt <= OW'(1);
            end
            OUT: if (out_end) begin
               dout    <= '0;
               out_cnt <= '0;
            end else begin
               dout    <= out_word;
               out_cnt <= out_cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Storage is not reset; a reset only has to stop any write in flight.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state == LOAD_W && data_ok) begin
            if (w_col == CW'(col1)) w1[w_row] <= din;
            if (w_col == CW'(col2)) w2[w_row] <= din;
         end
         if (state == LOAD_X && data_ok && x_end) begin
            z1[x_n] <= s1;
            z2[x_n] <= s2;
            y1[x_n] <= s1;
            y2[x_n] <= s2;
         end
         if (state == LOAD_E && hit) begin
            y1[de] <= e1;
            y2[de] <= e2;
         end
      end
   end

endmodule

// File: tb/tb_gcn_top.sv
// tb_gcn_top: directed jobs for gcn_top with a queue-based output scoreboard.
// The driver pushes expected words at terminator time; a monitor checks them.
module tb_gcn_top;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_req = 1'b0;
   logic        i_cmd = 1'b0;
   logic [15:0] din = 16'h0;
   wire         o_rdy;
   wire         o_result;
   wire  [15:0] dout;

   int          pass_cnt = 0;
   int          total_cnt = 0;
   logic [15:0] exp_q[$];

   always #5 clk = ~clk;

   gcn_top dut (
      .clk(clk), .rst(rst), .i_req(i_req), .i_cmd(i_cmd),
      .i_p0(din[0]),   .i_p1(din[1]),   .i_p2(din[2]),   .i_p3(din[3]),
      .i_p4(din[4]),   .i_p5(din[5]),   .i_p6(din[6]),   .i_p7(din[7]),
      .i_p8(din[8]),   .i_p9(din[9]),   .i_p10(din[10]), .i_p11(din[11]),
      .i_p12(din[12]), .i_p13(din[13]), .i_p14(din[14]), .i_p15(din[15]),
      .o_rdy(o_rdy), .o_result(o_result),
      .o_p0(dout[0]),   .o_p1(dout[1]),   .o_p2(dout[2]),   .o_p3(dout[3]),
      .o_p4(dout[4]),   .o_p5(dout[5]),   .o_p6(dout[6]),   .o_p7(dout[7]),
      .o_p8(dout[8]),   .o_p9(dout[9]),   .o_p10(dout[10]), .o_p11(dout[11]),
      .o_p12(dout[12]), .o_p13(dout[13]), .o_p14(dout[14]), .o_p15(dout[15])
   );

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h want %0h", name, act, exp);
   endtask

   // Job 0: identity W. Job 1: job 0 plus edges and noise.
   // Job 2: wrap and signed products. Job 3: col1 == col2, loops, dups.
   function automatic logic [15:0] hdr(input int id);
      case (id)
         2:       return 16'hFB08;
         3:       return 16'h0707;
         default: return 16'h0201;
      endcase
   endfunction

   function automatic logic [15:0] word0(input int id);
      case (id)
         2:       return 16'h0300;
         3:       return 16'h0707;
         default: return 16'h0201;
      endcase
   endfunction

   function automatic logic [15:0] w_val(input int kind, input int f,
                                         input int c);
      case (kind)
         0: return (f == c) ? 16'h0001 : 16'h0000;
         1: begin
            if (f == 0 && c == 0) return 16'h4000;
            if (f == 1 && c == 3) return 16'hFFFF;
            if (c == 0 || c == 3) return 16'h0000;
            return 16'h1234;
         end
         default: return (c == 7) ? 16'h0001 : 16'hBEEF;
      endcase
   endfunction

   function automatic logic [15:0] x_val(input int kind, input int n,
                                         input int f);
      case (kind)
         0: return 16'(n + f);
         1: return (f == 0) ? 16'h0004 : (f == 1) ? 16'(n) : 16'h0000;
         default: return 16'(f);
      endcase
   endfunction

   function automatic logic [15:0] exp_y(input int id, input int n,
                                         input int col);
      case (id)
         0: return 16'(n + 1 + col);
         1: begin
            if (n == 5) return (col == 0) ? 16'd9 : 16'd12;
            return 16'(n + 1 + col);
         end
         2: return (col == 0) ? 16'h0000 : 16'(0 - n);
         default: begin
            if (n == 3) return 16'd84;
            if (n == 0 || n == 99) return 16'd56;
            return 16'd28;
         end
      endcase
   endfunction

   task automatic send(input logic req, input logic cmd,
                       input logic [15:0] w);
      i_req = req;
      i_cmd = cmd;
      din   = w;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst   = 1'b1;
      i_req = 1'b0;
      i_cmd = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_rdy", 32'(o_rdy), 32'd0);
      chk("rst_result", 32'(o_result), 32'd0);
      chk("rst_p", 32'(dout), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic run_job(input int id, input int abort_x,
                          input int abort_out);
      int kind;
      int cyc;
      bit seen;
      bit done;
      kind = (id <= 1) ? 0 : id - 1;
      send(1'b1, 1'b0, hdr(id));
      for (int f = 0; f < 8; f++)
         for (int c = 0; c < 8; c++) begin
            if (id == 1 && f == 3 && c == 0) send(1'b1, 1'b1, 16'h5555);
            send(1'b0, 1'b0, w_val(kind, f, c));
         end
      for (int n = 0; n < 100; n++)
         for (int f = 0; f < 8; f++) begin
            if (n * 8 + f == abort_x) begin
               do_reset();
               return;
            end
            if (id == 1 && n == 40 && f == 2) send(1'b1, 1'b1, 16'h7777);
            send(1'b0, 1'b0, x_val(kind, n, f));
         end
      case (id)
         1: begin
            send(1'b0, 1'b1, 16'h0005);
            send(1'b0, 1'b0, 16'h0005);
            send(1'b0, 1'b1, 16'h0105);
            send(1'b0, 1'b0, 16'hFFFF);
            send(1'b0, 1'b1, 16'h6400);
         end
         2: begin
            send(1'b0, 1'b1, 16'h0064);
            send(1'b0, 1'b1, 16'h6464);
         end
         3: begin
            send(1'b0, 1'b1, 16'h0303);
            send(1'b0, 1'b1, 16'h0303);
            send(1'b0, 1'b1, 16'h6300);
            send(1'b0, 1'b1, 16'h0063);
            send(1'b0, 1'b1, 16'hFF00);
         end
         default: ;
      endcase
      send(1'b0, 1'b1, 16'hFFFF);
      exp_q.push_back(word0(id));
      for (int n = 0; n < 100; n++) exp_q.push_back(exp_y(id, n, 0));
      for (int n = 0; n < 100; n++) exp_q.push_back(exp_y(id, n, 1));
      // Header-like noise while the result streams out must be ignored.
      i_req = 1'b1;
      i_cmd = 1'b1;
      din   = 16'hFFFF;
      seen  = 1'b0;
      done  = 1'b0;
      for (cyc = 1; cyc <= 400 && !done; cyc++) begin
         @(posedge clk);
         #1;
         if (o_rdy) seen = 1'b1;
         if (seen && cyc == abort_out) begin
            do_reset();
            exp_q.delete();
            done = 1'b1;
         end else if (seen && !o_rdy) begin
            done = 1'b1;
         end
      end
      i_req = 1'b0;
      i_cmd = 1'b0;
      din   = 16'h0;
      if (!done) chk("job_timeout", 32'd0, 32'd1);
   endtask

   int run = 0;
   bit prev_rdy = 1'b0;
   bit prev_res = 1'b0;

   always @(negedge clk) begin
      if (rst) begin
         run      = 0;
         prev_rdy = 1'b0;
         prev_res = 1'b0;
      end else begin
         if (o_result) chk("fin_rdy", 32'(o_rdy), 32'd0);
         if (prev_res) chk("fin_pulse", {30'b0, o_result, o_rdy}, 32'd1);
         if (o_rdy) begin
            run++;
            if (exp_q.size() == 0) chk("stray_rdy", 32'(o_rdy), 32'd0);
            else chk($sformatf("word%0d", run - 1), 32'(dout),
                     32'(exp_q.pop_front()));
         end
         if (prev_rdy && !o_rdy) begin
            chk("rdy_len", 32'(run), 32'd201);
            chk("p_after", 32'(dout), 32'd0);
            run = 0;
         end
         prev_rdy = o_rdy;
         prev_res = o_result;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      #1;
      do_reset();
      run_job(0, -1, 0);
      run_job(1, -1, 0);
      run_job(2, -1, 0);
      run_job(3, -1, 0);
      run_job(1, 400, 0);
      run_job(0, -1, 0);
      run_job(3, -1, 60);
      run_job(2, -1, 0);
      repeat (3) @(posedge clk);
      #1;
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
